giant_counter_param: RTL and testbench
======================================

# giant_counter_param

Parametrised successor to the board-level 26-bit counter: a modulo-N up/down counter with 74163-style ENP/ENT/LD control, an integrated KEY0 debouncer/press detector, a threshold comparator, a ripple-carry output and a wrap toggle. It sits directly under the board top level, between the raw push-button/clock pins and the LED/IO0 indicators. It replaces the hand-wired debouncer + counter26bit + compare glue with one configurable block.

## Interface
- WIDTH, 26, counter width in bits
- MODULUS, 50_000_000, count range 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH
- THRESHOLD, 26_000_000, compare point for ABOVE
- MODE, 0, 0 = count every enabled clock; 1 = count one per debounced KEY0 press
- DEB_CYCLES, 500_000, stable-input cycles required by the debouncer (≥ 1)
- CLK50M  in  1  system clock; all state on rising edge
- CLR  in  1  reset, synchronous, active-high
- KEY0  in  1  raw push-button, active-low (0 = pressed), asynchronous to CLK50M
- ENP  in  1  count enable (parallel)
- ENT  in  1  count enable (trickle); also gates RCO
- LD  in  1  synchronous load
- D  in  WIDTH  load value
- UP  in  1  direction: 1 = up, 0 = down
- Q  out  WIDTH  counter value
- RCO  out  1  ripple carry, combinational
- ABOVE  out  1  Q ≥ THRESHOLD, combinational
- TOGGLE  out  1  flips on every wrap
- LED  out  4  Q[3:0]

## Operation
- Input path: KEY0 → 2-flop synchroniser → debouncer → clean level KEY_CLEAN → falling-edge detect → one-cycle PRESS pulse.
- Debouncer: internal counter clears whenever synchronised KEY0 equals KEY_CLEAN; otherwise increments; when it reaches DEB_CYCLES-1, KEY_CLEAN takes the new value and the counter clears.
- Count qualifier CE = ENP & ENT & (MODE==0 ? 1 : PRESS).
- Priority per clock: CLR > LD > CE count > hold.
- CLR: Q=0, TOGGLE=0, synchroniser flops=1, KEY_CLEAN=1, debounce counter=0, PRESS=0.
- LD: Q = D if D < MODULUS, else MODULUS-1. Does not touch TOGGLE. Overrides a coincident CE.
- Count up: Q==MODULUS-1 → Q=0 and wrap; else Q+1.
- Count down: Q==0 → Q=MODULUS-1 and wrap; else Q-1.
- Wrap: TOGGLE inverts in the same clock as Q wraps.
- RCO = ENT & (UP ? Q==MODULUS-1 : Q==0); independent of ENP and MODE.
- ABOVE = (Q ≥ THRESHOLD). If THRESHOLD ≥ MODULUS, ABOVE is constant 0.
- All comparisons are unsigned, WIDTH bits. No intermediate value exceeds WIDTH bits.
- A UP change takes effect on the next CE. It is legal at any count, including terminal.

## Timing
- Reset values: Q=0, TOGGLE=0, LED=0, ABOVE=(THRESHOLD==0), RCO=ENT & ~UP.
- Q, TOGGLE: registered, update on the clock edge after the qualifying inputs.
- RCO, ABOVE, LED: combinational from Q and inputs; no added latency.
- Press latency (debounce enabled): KEY0 falls at edge 0 and is held low → synchronised at edge 2 → KEY_CLEAN falls at edge 2+DEB_CYCLES → PRESS high for exactly one cycle after that → Q changes one edge later.
- Bounce shorter than DEB_CYCLES consecutive cycles produces no PRESS.
- Release never produces PRESS.
- A press held indefinitely gives exactly one PRESS.
- CLR mid-debounce aborts the debounce; no PRESS is generated afterwards for that press unless KEY0 releases and presses again.
- PRESS while ENP or ENT is low is discarded, not queued.

## Configuration
- GIANT_COUNTER_DEBOUNCE_EN defined: debouncer instantiated as above.
- GIANT_COUNTER_DEBOUNCE_EN undefined: KEY_CLEAN is the synchroniser output directly, DEB_CYCLES is ignored, and press latency is 3 edges (2 sync + edge detect).
- All other behaviour is identical in both builds.

## Test plan
Parameters for all cases: WIDTH=8, MODULUS=10, THRESHOLD=6, DEB_CYCLES=4, debounce enabled unless stated.
- Free-run (MODE=0): CLR, then ENP=ENT=UP=1 for 12 clocks → Q sequence 1..9,0,1,2; TOGGLE=1 after the 10th clock; RCO high only while Q=9; ABOVE high for Q 6..9.
- Down and load: LD=1, D=3, then UP=0 for 4 clocks → Q 3,2,1,0,9; wrap flips TOGGLE. LD with D=200 → Q=9. LD and CE in the same cycle → load wins.
- Press count (MODE=1): KEY0 low for 10 cycles → exactly one increment at 2+4+2 edges after the fall. Three clean presses → Q=3.
- Bounce reject (MODE=1): KEY0 toggling with low pulses of 3 cycles → Q unchanged. Press while ENT=0 → Q unchanged and RCO=0.
- Reset mid-operation: CLR asserted at Q=7 with TOGGLE=1 and KEY0 mid-debounce → next edge Q=0, TOGGLE=0; held press gives no count until released and re-pressed.
- Macro off (GIANT_COUNTER_DEBOUNCE_EN undefined, MODE=1): 1-cycle KEY0 low pulse → one increment, 3 edges after the fall.

Source files
------------

// File: rtl/giant_counter_param.sv
// giant_counter_param
// Modulo-MODULUS up/down counter with 74163-style ENP/ENT/LD control, a KEY0
// synchroniser and press detector, a threshold comparator (ABOVE), a ripple-carry
// output (RCO) and a toggle that flips on every wrap.
// Build option: define GIANT_COUNTER_DEBOUNCE_EN to include the KEY0 debouncer
// (DEB_CYCLES stable cycles). When it is undefined, the synchronised key is used
// directly as the clean level and DEB_CYCLES is ignored.
module giant_counter_param #(
   parameter int unsigned     WIDTH      = 26,
   parameter longint unsigned MODULUS    = 50_000_000,
   parameter longint unsigned THRESHOLD  = 26_000_000,
   parameter int unsigned     MODE       = 0,
   parameter int unsigned     DEB_CYCLES = 500_000
) (
   input  logic             CLK50M,
   input  logic             CLR,
   input  logic             KEY0,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             UP,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             ABOVE,
   output logic             TOGGLE,
   output logic [3:0]       LED
);

   // Terminal count; MODULUS == 2^WIDTH folds to all ones without widening.
   localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
   // A threshold at or beyond the count range can never be reached.
   localparam bit               AboveEn = (THRESHOLD < MODULUS);
   localparam logic [WIDTH-1:0] ThrVal  = AboveEn ? WIDTH'(THRESHOLD) : '0;

   logic             key_meta_q;
   logic             key_sync_q;
   logic             key_clean;
   logic             press_d;
   logic             press_q;
   logic             press;
   logic             fill_q;
   logic             lock_q;
   logic             ce;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             tog_q;
   logic             tog_d;

   // Two-flop synchroniser; CLR parks both stages at the released (high) level.
   always_ff @(posedge CLK50M) begin
      if (CLR) begin
         key_meta_q <= 1'b1;
         key_sync_q <= 1'b1;
      end else begin
         key_meta_q <= KEY0;
         key_sync_q <= key_meta_q;
      end
   end

`ifdef GIANT_COUNTER_DEBOUNCE_EN
   localparam int unsigned     DebW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

   logic [DebW-1:0] deb_cnt_q;
   logic [DebW-1:0] deb_cnt_d;
   logic            key_clean_q;
   logic            key_clean_d;
   logic            clean_dly_q;

   // Debounce: count consecutive cycles the synchronised key disagrees with the
   // clean level; accept the new level once the count reaches DEB_CYCLES-1.
   always_comb begin
      deb_cnt_d   = '0;
      key_clean_d = key_clean_q;
      if (key_sync_q != key_clean_q) begin
         if (deb_cnt_q == DebLast) begin
            key_clean_d = key_sync_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
         end
      end
   end

   // Debouncer state and the delayed clean level used for falling-edge detect.
   always_ff @(posedge CLK50M) begin
      if (CLR) begin
         deb_cnt_q   <= '0;
         key_clean_q <= 1'b1;
         clean_dly_q <= 1'b1;
      end else begin
         deb_cnt_q   <= deb_cnt_d;
         key_clean_q <= key_clean_d;
         clean_dly_q <= key_clean;
      end
   end

   assign key_clean = key_clean_q;
   assign press_d   = clean_dly_q & ~key_clean;
`else
   logic unused_deb;

   // No debouncer: the synchroniser output is the clean level, and its falling
   // edge is seen one stage early against the metastability flop.
   assign key_clean  = key_sync_q;
   assign press_d    = key_clean & ~key_meta_q;
   assign unused_deb = ^DEB_CYCLES;
`endif

   // Press pulse register plus the post-CLR lockout: a key already held through
   // CLR stays masked until KEY0 is seen high on a genuine (post-CLR) sample.
   always_ff @(posedge CLK50M) begin
      if (CLR) begin
         press_q <= 1'b0;
         fill_q  <= 1'b0;
         lock_q  <= 1'b1;
      end else begin
         press_q <= press_d;
         fill_q  <= 1'b1;
         if (fill_q && key_meta_q) begin
            lock_q <= 1'b0;
         end
      end
   end

   assign press = press_q & ~lock_q;

   // Count qualifier: a press that arrives while ENP/ENT is low is simply lost.
   assign ce = ENP & ENT & ((MODE == 0) ? 1'b1 : press);

   // Next count: LD beats counting; wraps at either end flip the toggle.
   always_comb begin
      q_d   = q_q;
      tog_d = tog_q;
      if (LD) begin
         q_d = (D <= MaxVal) ? D : MaxVal;
      end else if (ce) begin
         if (UP) begin
            if (q_q == MaxVal) begin
               q_d   = '0;
               tog_d = ~tog_q;
            end else begin
               q_d = q_q + WIDTH'(1);
            end
         end else begin
            if (q_q == '0) begin
               q_d   = MaxVal;
               tog_d = ~tog_q;
            end else begin
               q_d = q_q - WIDTH'(1);
            end
         end
      end
   end

   // Count and toggle registers with synchronous clear.
   always_ff @(posedge CLK50M) begin
      if (CLR) begin
         q_q   <= '0;
         tog_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         tog_q <= tog_d;
      end
   end

   assign Q      = q_q;
   assign TOGGLE = tog_q;
   assign LED    = q_q[3:0];
   assign RCO    = ENT & (UP ? (q_q == MaxVal) : (q_q == '0));
   assign ABOVE  = AboveEn & (q_q >= ThrVal);

endmodule

// File: tb/tb_giant_counter_param.sv
// Bench for giant_counter_param (WIDTH=8, MODULUS=10, THRESHOLD=6, DEB_CYCLES=4).
// Two instances share all inputs: u_free (MODE=0) and u_press (MODE=1).
module tb_giant_counter_param;

   localparam int Mod = 10;
   localparam int Thr = 6;
   localparam int Deb = 4;
`ifdef GIANT_COUNTER_DEBOUNCE_EN
   localparam int PressLat  = 2;            // clean fall -> count edge
   localparam int PressEdge = 2 + Deb + 2;  // key fall -> count edge
   localparam int HoldLen   = 10;
`else
   localparam int PressLat  = 1;
   localparam int PressEdge = 3;
   localparam int HoldLen   = 1;
`endif

   logic       clk = 1'b0;
   logic       clr, ld, enp, ent, up, key;
   logic [7:0] d;
   logic [7:0] dq [2];
   logic       drco [2];
   logic       dabove [2];
   logic       dtog [2];
   logic [3:0] dled [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   giant_counter_param #(
      .WIDTH(8), .MODULUS(10), .THRESHOLD(6), .MODE(0), .DEB_CYCLES(4)
   ) u_free (
      .CLK50M(clk), .CLR(clr), .KEY0(key), .ENP(enp), .ENT(ent), .LD(ld), .D(d), .UP(up),
      .Q(dq[0]), .RCO(drco[0]), .ABOVE(dabove[0]), .TOGGLE(dtog[0]), .LED(dled[0])
   );

   giant_counter_param #(
      .WIDTH(8), .MODULUS(10), .THRESHOLD(6), .MODE(1), .DEB_CYCLES(4)
   ) u_press (
      .CLK50M(clk), .CLR(clr), .KEY0(key), .ENP(enp), .ENT(ent), .LD(ld), .D(d), .UP(up),
      .Q(dq[1]), .RCO(drco[1]), .ABOVE(dabove[1]), .TOGGLE(dtog[1]), .LED(dled[1])
   );

   // Reference model state
   int       mq [2];
   bit       mt [2];
   bit       m_clean = 1'b1;
   bit       m_lock = 1'b1;
   bit       last_hi = 1'b0;
   bit [3:0] pend = '0;
   bit       samp1 = 1'b1;
`ifdef GIANT_COUNTER_DEBOUNCE_EN
   bit       samp2 = 1'b1;
   int       run = 0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("q%0d", i), 32'(dq[i]), mq[i]);
         chk($sformatf("toggle%0d", i), 32'(dtog[i]), int'(mt[i]));
         chk($sformatf("rco%0d", i), 32'(drco[i]),
             int'(ent && (up ? (mq[i] == Mod - 1) : (mq[i] == 0))));
         chk($sformatf("above%0d", i), 32'(dabove[i]), int'(mq[i] >= Thr));
         chk($sformatf("led%0d", i), 32'(dled[i]), mq[i] % 16);
      end
   endtask

   // One clock: advance the model from the inputs present at the edge, then compare.
   task automatic tick();
      bit p_eff, ce, prev_clean;
      @(posedge clk);
      p_eff = pend[0] & ~m_lock;
      pend  = pend >> 1;
      for (int i = 0; i < 2; i++) begin
         ce = enp && ent && ((i == 0) ? 1'b1 : p_eff);
         if (clr) begin
            mq[i] = 0;
            mt[i] = 1'b0;
         end else if (ld) begin
            mq[i] = (int'(d) < Mod) ? int'(d) : Mod - 1;
         end else if (ce) begin
            if (up) begin
               mq[i] = mq[i] + 1;
               if (mq[i] == Mod) begin
                  mq[i] = 0;
                  mt[i] = ~mt[i];
               end
            end else if (mq[i] == 0) begin
               mq[i] = Mod - 1;
               mt[i] = ~mt[i];
            end else begin
               mq[i] = mq[i] - 1;
            end
         end
      end
      if (clr) begin
         m_clean = 1'b1;
         m_lock  = 1'b1;
         last_hi = 1'b0;
         pend    = '0;
         samp1   = 1'b1;
`ifdef GIANT_COUNTER_DEBOUNCE_EN
         samp2   = 1'b1;
         run     = 0;
`endif
      end else begin
         prev_clean = m_clean;
`ifdef GIANT_COUNTER_DEBOUNCE_EN
         if (samp2 != m_clean) begin
            run++;
            if (run == Deb) begin
               m_clean = samp2;
               run = 0;
            end
         end else begin
            run = 0;
         end
         samp2 = samp1;
`else
         m_clean = samp1;
`endif
         if (prev_clean && !m_clean) pend[PressLat-1] = 1'b1;
         samp1 = key;
         if (last_hi) m_lock = 1'b0;
         last_hi = key;
      end
      #1;
      check_model();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (3) tick();
   endtask

   task automatic press_once();
      key = 1'b0;
      repeat (HoldLen) tick();
      key = 1'b1;
      repeat (14) tick();
   endtask

   typedef struct {
      bit clr, ld, enp, ent, up;
      int d;
      int q;
      bit tog, rco, above;
   } vec_t;

   function automatic vec_t mk(bit c, bit l, bit p, bit t, bit u, int dv,
                               int eq, bit et, bit er, bit ea);
      vec_t v;
      v.clr = c; v.ld = l; v.enp = p; v.ent = t; v.up = u; v.d = dv;
      v.q = eq; v.tog = et; v.rco = er; v.above = ea;
      return v;
   endfunction

   vec_t vt[$];

   initial begin
      int hit, nchg, base, key_left;
      logic [7:0] prev;

      clr = 1'b0; ld = 1'b0; enp = 1'b0; ent = 1'b0; up = 1'b1; key = 1'b1; d = '0;
      mq[0] = 0; mq[1] = 0; mt[0] = 1'b0; mt[1] = 1'b0;

      // Free-run, down count, load clamp and load-over-count vectors for u_free
      vt.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 12; k++)
         vt.push_back(mk(0, 0, 1, 1, 1, 0, k % 10, k >= 10, (k % 10) == 9, (k % 10) >= 6));
      vt.push_back(mk(0, 1, 1, 1, 0, 3, 3, 1, 0, 0));
      vt.push_back(mk(0, 0, 1, 1, 0, 0, 2, 1, 0, 0));
      vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
      vt.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0));
      vt.push_back(mk(0, 0, 1, 1, 0, 0, 9, 0, 0, 1));
      vt.push_back(mk(0, 1, 1, 1, 0, 200, 9, 0, 0, 1));
      vt.push_back(mk(0, 1, 1, 1, 1, 5, 5, 0, 0, 0));

      foreach (vt[i]) begin
         clr = vt[i].clr; ld = vt[i].ld; enp = vt[i].enp; ent = vt[i].ent;
         up = vt[i].up; d = 8'(vt[i].d);
         tick();
         chk($sformatf("vec%0d_q", i), 32'(dq[0]), vt[i].q);
         chk($sformatf("vec%0d_toggle", i), 32'(dtog[0]), int'(vt[i].tog));
         chk($sformatf("vec%0d_rco", i), 32'(drco[0]), int'(vt[i].rco));
         chk($sformatf("vec%0d_above", i), 32'(dabove[0]), int'(vt[i].above));
      end
      ld = 1'b0;

      // Press latency: one count at PressEdge edges after the fall
      enp = 1'b1; ent = 1'b1; up = 1'b1;
      do_clr();
      key = 1'b0; hit = -1; nchg = 0; prev = dq[1];
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (e == HoldLen) key = 1'b1;
         if (dq[1] !== prev) begin
            nchg++;
            if (hit < 0) hit = e;
         end
         prev = dq[1];
      end
      chk("press_latency", 32'(hit), PressEdge);
      chk("press_count", 32'(nchg), 1);
      chk("press_q", 32'(dq[1]), 1);

      // Three clean presses
      do_clr();
      repeat (3) press_once();
      chk("three_presses", 32'(dq[1]), 3);

      // Short low pulses: rejected with the debouncer, each counts without it
      do_clr();
      repeat (4) begin
         key = 1'b0; repeat (3) tick();
         key = 1'b1; repeat (3) tick();
      end
      repeat (10) tick();
`ifdef GIANT_COUNTER_DEBOUNCE_EN
      chk("bounce_reject", 32'(dq[1]), 0);
`else
      chk("short_pulses", 32'(dq[1]), 4);
`endif

      // Press while ENT low is discarded
      base = int'(dq[1]);
      ent = 1'b0;
      press_once();
      chk("ent_low_press", 32'(dq[1]), base);
      chk("ent_low_rco", 32'(drco[1]), 0);
      ent = 1'b1;
      tick();
      chk("ent_low_not_queued", 32'(dq[1]), base);

      // CLR mid-debounce with a held key
      ld = 1'b1; d = 8'd9; tick(); ld = 1'b0;
      press_once();
      chk("wrap_q", 32'(dq[1]), 0);
      chk("wrap_toggle", 32'(dtog[1]), 1);
      ld = 1'b1; d = 8'd7; tick(); ld = 1'b0;
      chk("pre_clr_q", 32'(dq[1]), 7);
      key = 1'b0;
      repeat (2) tick();
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_q", 32'(dq[1]), 0);
      chk("clr_toggle", 32'(dtog[1]), 0);
      repeat (20) tick();
      chk("held_after_clr", 32'(dq[1]), 0);
      key = 1'b1;
      repeat (6) tick();
      press_once();
      chk("repress_after_clr", 32'(dq[1]), 1);

      // Randomised run against the model
      key_left = 0;
      for (int n = 0; n < 4000; n++) begin
         clr = ($urandom_range(0, 99) == 0);
         ld  = ($urandom_range(0, 19) == 0);
         enp = ($urandom_range(0, 7) != 0);
         ent = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) up = ~up;
         d = 8'($urandom_range(0, 255));
         if (key_left == 0) begin
            key = ~key;
            key_left = $urandom_range(1, 12);
         end
         key_left--;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
